dq_ser8_wrpath: RTL and testbench



---
 rtl/dq_ser8_wrpath.sv | 137 +++++++++++++
 tb/tb_dq_ser8_wrpath.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dq_ser8_wrpath.sv
// dq_ser8_wrpath: write-path gearbox feeding per-lane OSER8 serializers.
// Accepts burst beats over valid/ready and presents one registered 8-bit word
// per lane per pclk. It also drives the shared OSER8 tristate control so the
// pads are only driven across preamble, data and postamble. Back-to-back
// bursts merge through the postamble without re-issuing a preamble.
module dq_ser8_wrpath #(
  parameter int         LANES       = 8,
  parameter int         PRE_CYCLES  = 1,
  parameter int         POST_CYCLES = 1,
  parameter int         MAX_BEATS   = 16,
  parameter logic [7:0] IDLE_VAL    = 8'h00
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [LANES*8-1:0] wr_data,
  input  logic               wr_last,
  output logic [LANES*8-1:0] ser_d,
  output logic [3:0]         ser_oen,
  output logic               busy,
  output logic               err_underrun,
  output logic               err_overrun
);

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [2:0]    PRE_LAST  = 3'((PRE_CYCLES  > 0) ? PRE_CYCLES  - 1 : 0);
  localparam logic [2:0]    POST_LAST = 3'((POST_CYCLES > 0) ? POST_CYCLES - 1 : 0);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_POST = 2'd3
  } state_t;

  // Word driven on every lane whenever no beat is being transferred.
  function automatic logic [LANES*8-1:0] idle_word();
    return {LANES{IDLE_VAL}};
  endfunction

  state_t          state_p0;
  state_t          state_nxt;
  logic [2:0]      phase_cnt_p0;
  logic [BW-1:0]   beat_cnt_p0;
  logic            accept;
  logic            beat_max;
  logic            burst_end;

  logic [LANES*8-1:0] ser_d_nxt;
  logic [3:0]         ser_oen_nxt;
  logic               wr_ready_nxt;
  logic               busy_nxt;

  // wr_ready is registered as (next state == DATA), so it is high exactly
  // while the FSM sits in DATA.
  assign accept    = (state_p0 == S_DATA) && wr_valid;
  assign beat_max  = (beat_cnt_p0 == BEAT_LAST);
  assign burst_end = accept && (wr_last || beat_max);

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) state_p0 <= S_IDLE;
    else     state_p0 <= state_nxt;
  end

  // Next-state decode; postamble merges straight into DATA when a beat waits.
  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      S_IDLE: begin
        if (wr_valid) state_nxt = (PRE_CYCLES > 0) ? S_PRE : S_DATA;
      end
      S_PRE: begin
        if (phase_cnt_p0 == PRE_LAST) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (burst_end) state_nxt = (POST_CYCLES > 0) ? S_POST : S_IDLE;
      end
      S_POST: begin
        if (phase_cnt_p0 == POST_LAST) state_nxt = wr_valid ? S_DATA : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Phase counter times PRE/POST; beat counter limits burst length, never wraps.
  always_ff @(posedge pclk) begin
    if (rst) begin
      phase_cnt_p0 <= '0;
      beat_cnt_p0  <= '0;
    end else begin
      if (state_nxt != state_p0)                       phase_cnt_p0 <= '0;
      else if (state_p0 == S_PRE || state_p0 == S_POST) phase_cnt_p0 <= phase_cnt_p0 + 3'd1;
      if (burst_end)   beat_cnt_p0 <= '0;
      else if (accept) beat_cnt_p0 <= beat_cnt_p0 + 1'b1;
    end
  end

  // Output decode: bus content and drive enable follow the current state, so
  // the pad view lags the FSM by one pclk like the data does.
  always_comb begin
    ser_d_nxt    = accept ? wr_data : idle_word();
    ser_oen_nxt  = (state_p0 == S_IDLE) ? 4'hF : 4'h0;
    wr_ready_nxt = (state_nxt == S_DATA);
    busy_nxt     = (state_nxt != S_IDLE);
  end

  // ---- output register stage (p1) ----
  // Registered outputs; reset puts the pads in high-Z with idle data.
  always_ff @(posedge pclk) begin
    if (rst) begin
      ser_d    <= idle_word();
      ser_oen  <= 4'hF;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ser_d    <= ser_d_nxt;
      ser_oen  <= ser_oen_nxt;
      wr_ready <= wr_ready_nxt;
      busy     <= busy_nxt;
    end
  end

  // Sticky error flags: missing beat inside DATA, or burst hitting MAX_BEATS.
  always_ff @(posedge pclk) begin
    if (rst) begin
      err_underrun <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      if ((state_p0 == S_DATA) && !wr_valid)    err_underrun <= 1'b1;
      if (accept && beat_max && !wr_last)       err_overrun  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dq_ser8_wrpath.sv
// Bench for dq_ser8_wrpath: directed bursts, expected driven-bus words queued
// at issue time and consumed by an independent negedge monitor.
module tb_dq_ser8_wrpath;

  localparam int LANES = 8;
  localparam int W     = LANES * 8;

  logic         pclk;
  logic         rst;
  logic         wr_valid;
  logic         wr_ready;
  logic [W-1:0] wr_data;
  logic         wr_last;
  logic [W-1:0] ser_d;
  logic [3:0]   ser_oen;
  logic         busy;
  logic         err_underrun;
  logic         err_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  bit mon_en   = 0;
  bit prev_drv = 0;

  dq_ser8_wrpath #(
    .LANES(LANES), .PRE_CYCLES(1), .POST_CYCLES(1), .MAX_BEATS(4), .IDLE_VAL(8'h00)
  ) dut (
    .pclk(pclk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .ser_d(ser_d), .ser_oen(ser_oen),
    .busy(busy), .err_underrun(err_underrun), .err_overrun(err_overrun)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every driven bus cycle consumes one expected word.
  always @(negedge pclk) begin
    if (mon_en) begin
      if (ser_oen == 4'h0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_drive: ser_d %h driven with no expected word", ser_d);
        end else begin
          check("ser_d", ser_d, exp_q.pop_front());
        end
        prev_drv = 1;
      end else begin
        check("ser_oen_released", {60'd0, ser_oen}, 64'hF);
        check("ser_d_idle_when_released", ser_d, 64'd0);
        if (prev_drv && exp_q.size() != 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bus_released_mid_burst: %0d words still expected", exp_q.size());
        end
        prev_drv = 0;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Present one beat and hold it until the DUT takes it (bounded).
  task automatic beat(input logic [W-1:0] d, input logic last);
    bit done;
    done     = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (wr_ready) done = 1;
      @(posedge pclk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_accept_timeout: beat %h never accepted", d);
    end
  endtask

  task automatic release_bus();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick(1);
    tick(2);
    check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_oen_idle"}, {60'd0, ser_oen}, 64'hF);
    check({name, "_busy_idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_underrun_clear", {63'd0, err_underrun}, 64'd0);
    check("rst_overrun_clear", {63'd0, err_overrun}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    tick(1);
    mon_en = 1;
    tick(2);
    rst = 1'b0;

    // Reset state held through 10 idle cycles
    for (int i = 0; i < 10; i++) begin
      check("idle_oen", {60'd0, ser_oen}, 64'hF);
      check("idle_ser_d", ser_d, 64'd0);
      check("idle_ready", {63'd0, wr_ready}, 64'd0);
      check("idle_busy", {63'd0, busy}, 64'd0);
      tick(1);
    end
    check("idle_err_u", {63'd0, err_underrun}, 64'd0);
    check("idle_err_o", {63'd0, err_overrun}, 64'd0);

    // Two-beat burst: pre, data, data, post
    exp_q.push_back(64'd0);
    exp_q.push_back(64'h0123456789ABCDEF);
    exp_q.push_back(64'hFEDCBA9876543210);
    exp_q.push_back(64'd0);
    beat(64'h0123456789ABCDEF, 1'b0);
    check("busy_in_burst", {63'd0, busy}, 64'd1);
    beat(64'hFEDCBA9876543210, 1'b1);
    release_bus();
    drain("burst2");
    check("burst2_err_u", {63'd0, err_underrun}, 64'd0);
    check("burst2_err_o", {63'd0, err_overrun}, 64'd0);

    // Underrun: one missing beat inside DATA
    exp_q.push_back(64'd0);
    exp_q.push_back(64'hA5A5A5A5_5A5A5A5A);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'h1357_9BDF_2468_ACE0);
    exp_q.push_back(64'd0);
    beat(64'hA5A5A5A5_5A5A5A5A, 1'b0);
    release_bus();
    tick(1);
    check("underrun_set", {63'd0, err_underrun}, 64'd1);
    beat(64'h1357_9BDF_2468_ACE0, 1'b1);
    release_bus();
    drain("underrun");
    tick(5);
    check("underrun_sticky", {63'd0, err_underrun}, 64'd1);

    // Overrun: 6 beats, wr_last only on the 6th, MAX_BEATS = 4
    exp_q.push_back(64'd0);
    exp_q.push_back(64'h1111_1111_1111_1111);
    exp_q.push_back(64'h2222_2222_2222_2222);
    exp_q.push_back(64'h3333_3333_3333_3333);
    exp_q.push_back(64'h4444_4444_4444_4444);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'h5555_5555_5555_5555);
    exp_q.push_back(64'h6666_6666_6666_6666);
    exp_q.push_back(64'd0);
    beat(64'h1111_1111_1111_1111, 1'b0);
    beat(64'h2222_2222_2222_2222, 1'b0);
    beat(64'h3333_3333_3333_3333, 1'b0);
    check("no_overrun_yet", {63'd0, err_overrun}, 64'd0);
    beat(64'h4444_4444_4444_4444, 1'b0);
    check("overrun_set", {63'd0, err_overrun}, 64'd1);
    check("post_ready_low", {63'd0, wr_ready}, 64'd0);
    beat(64'h5555_5555_5555_5555, 1'b0);
    beat(64'h6666_6666_6666_6666, 1'b1);
    release_bus();
    drain("overrun");
    check("overrun_sticky", {63'd0, err_overrun}, 64'd1);
    check("underrun_still_sticky", {63'd0, err_underrun}, 64'd1);

    do_reset();
    tick(2);

    // Back-to-back bursts merge through one postamble cycle
    exp_q.push_back(64'd0);
    exp_q.push_back(64'hAAAA_0000_AAAA_0001);
    exp_q.push_back(64'hAAAA_0000_AAAA_0002);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'hBBBB_0000_BBBB_0001);
    exp_q.push_back(64'hBBBB_0000_BBBB_0002);
    exp_q.push_back(64'd0);
    beat(64'hAAAA_0000_AAAA_0001, 1'b0);
    beat(64'hAAAA_0000_AAAA_0002, 1'b1);
    beat(64'hBBBB_0000_BBBB_0001, 1'b0);
    beat(64'hBBBB_0000_BBBB_0002, 1'b1);
    release_bus();
    drain("merge");
    check("merge_err_u", {63'd0, err_underrun}, 64'd0);
    check("merge_err_o", {63'd0, err_overrun}, 64'd0);

    // Reset on the second data beat of a 4-beat burst
    exp_q.push_back(64'd0);
    exp_q.push_back(64'hC0C0_C0C0_C0C0_C001);
    beat(64'hC0C0_C0C0_C0C0_C001, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 64'hC0C0_C0C0_C0C0_C002;
    wr_last  = 1'b0;
    rst      = 1'b1;
    tick(1);
    check("rst_mid_oen", {60'd0, ser_oen}, 64'hF);
    check("rst_mid_ready", {63'd0, wr_ready}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_ser_d", ser_d, 64'd0);
    rst = 1'b0;
    release_bus();
    tick(3);
    check("rst_mid_queue", 64'(exp_q.size()), 64'd0);
    check("rst_mid_stays_idle", {63'd0, busy}, 64'd0);

    // New burst after reset starts with a full preamble
    exp_q.push_back(64'd0);
    exp_q.push_back(64'hD00D_D00D_D00D_0001);
    exp_q.push_back(64'hD00D_D00D_D00D_0002);
    exp_q.push_back(64'd0);
    beat(64'hD00D_D00D_D00D_0001, 1'b0);
    beat(64'hD00D_D00D_D00D_0002, 1'b1);
    release_bus();
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
